fetch_unit: RTL and testbench

- Instruction-fetch and PC-sequencing stage directly upstream of the main/ALU decoders.
- Holds the PC and fetches one word from instruction memory over a req/rvalid handshake.
- Presents the registered instruction word to decode as op = instr[31:26] and funct = instr[5:0].
- On commit, takes the decoder's pc_src/jump outcome, computes the next PC (sequential, branch or jump) and starts the next fetch.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch and PC-sequencing stage: fetches one word per instruction over a
// req/rvalid handshake, holds it for decode and computes the next PC on commit.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [5:0]  funct_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        commit_i,
  input  logic        pc_src_i,
  input  logic        jump_i
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] branch_off_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] jump_tgt_s;
  logic [31:0] next_pc_s;

  // Candidate targets; all are word-aligned, so pc_q[1:0] never leaves 2'b00.
  always_comb begin
    pc_plus4_s   = pc_q + 32'd4;
    branch_off_s = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branch_tgt_s = pc_plus4_s + branch_off_s;
    jump_tgt_s   = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
  end

  // Next-PC select: jump beats branch, branch beats sequential.
  always_comb begin
    if (jump_i) begin
      next_pc_s = jump_tgt_s;
    end else if (pc_src_i) begin
      next_pc_s = branch_tgt_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // FETCH/HOLD next-state logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      FETCH: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (commit_i) begin
          pc_d    = next_pc_s;
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

  // State, PC and instruction registers; reset restarts a fresh fetch at RESET_PC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Gating with rst_ni keeps the request low for the whole reset window.
  assign imem_req_o    = (state_q == FETCH) && rst_ni;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4_s;
  assign instr_o       = instr_q;
  assign op_o          = instr_q[31:26];
  assign funct_o       = instr_q[5:0];
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit with a behavioural PC/instruction model.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0000_0000;
  logic [31:0] instr_o;
  logic [5:0]  op_o;
  logic [5:0]  funct_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        commit_i = 1'b0;
  logic        pc_src_i = 1'b0;
  logic        jump_i = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_m;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .op_o(op_o), .funct_o(funct_o),
    .instr_valid_o(instr_valid_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .commit_i(commit_i), .pc_src_i(pc_src_i), .jump_i(jump_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference next-PC from the architectural rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic br, input logic jp);
    logic [31:0] seq;
    int off;
    seq = pc + 32'd4;
    if (jp) return (seq & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 32'd4;
    if (br) begin
      off = int'(ins & 32'h0000_FFFF);
      if (off >= 32768) off = off - 65536;
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Fetch one instruction with 'waits' wait states, hold it 'hold' cycles, then commit.
  // Starts and ends on a falling edge with the DUT expected in FETCH at pc_m.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int waits,
                           input int hold, input logic br, input logic jp);
    logic [31:0] exp_next;
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== pc_m || pc_o !== pc_m || instr_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_fetch cyc%0d: req=%0b addr=%h pc=%h valid=%0b, expected req=1 addr=pc=%h valid=0",
                 tag, i, imem_req_o, imem_addr_o, pc_o, instr_valid_o, pc_m);
      end
      checks++;
      if (pc_plus4_o !== pc_m + 32'd4) begin
        errors++;
        $display("FAIL %s_pc_plus4: got %h expected %h", tag, pc_plus4_o, pc_m + 32'd4);
      end
      imem_rvalid_i = (i == waits);
      imem_rdata_i  = (i == waits) ? ins : $urandom;
      commit_i      = 1'($urandom_range(0, 1));
      pc_src_i      = 1'($urandom_range(0, 1));
      jump_i        = 1'($urandom_range(0, 1));
      @(negedge clk_i);
    end
    imem_rvalid_i = 1'b0;
    commit_i      = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== ins || imem_req_o !== 1'b0 || pc_o !== pc_m) begin
        errors++;
        $display("FAIL %s_hold cyc%0d: valid=%0b instr=%h req=%0b pc=%h, expected valid=1 instr=%h req=0 pc=%h",
                 tag, i, instr_valid_o, instr_o, imem_req_o, pc_o, ins, pc_m);
      end
      checks++;
      if (op_o !== ins[31:26] || funct_o !== ins[5:0]) begin
        errors++;
        $display("FAIL %s_decode: op=%h funct=%h expected op=%h funct=%h",
                 tag, op_o, funct_o, ins[31:26], ins[5:0]);
      end
      if (i == hold) begin
        commit_i = 1'b1;
        pc_src_i = br;
        jump_i   = jp;
      end else begin
        commit_i      = 1'b0;
        pc_src_i      = 1'($urandom_range(0, 1));
        jump_i        = 1'($urandom_range(0, 1));
        imem_rvalid_i = 1'($urandom_range(0, 1));
        imem_rdata_i  = $urandom;
      end
      @(negedge clk_i);
    end
    commit_i      = 1'b0;
    pc_src_i      = 1'b0;
    jump_i        = 1'b0;
    imem_rvalid_i = 1'b0;
    exp_next = ref_next(pc_m, ins, br, jp);
    checks++;
    if (pc_o !== exp_next || imem_addr_o !== exp_next || instr_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_next: pc=%h addr=%h valid=%0b req=%0b, expected pc=addr=%h valid=0 req=1",
               tag, pc_o, imem_addr_o, instr_valid_o, imem_req_o, exp_next);
    end
    pc_m = exp_next;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (pc_o !== 32'h0000_0000 || instr_o !== 32'h0000_0000 || instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: pc=%h instr=%h valid=%0b req=%0b, expected 0/0/0/0",
               pc_o, instr_o, instr_valid_o, imem_req_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pc_m = 32'h0000_0000;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_release: req=%0b addr=%h, expected req=1 addr=00000000", imem_req_o, imem_addr_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (imem_addr_o !== 32'(k * 4)) begin
        errors++;
        $display("FAIL seq_addr%0d: got %h expected %h", k, imem_addr_o, 32'(k * 4));
      end
      run_instr("seq", 32'h0000_0000, 0, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_wait_state();
    run_instr("seq3", 32'h0000_0000, 0, 0, 1'b0, 1'b0);
    checks++;
    if (imem_addr_o !== 32'h0000_0010) begin
      errors++;
      $display("FAIL wait_addr: got %h expected 00000010", imem_addr_o);
    end
    run_instr("wait", 32'h0123_4567, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("to20", 32'h0800_0008, 0, 0, 1'b0, 1'b1);
    run_instr("beq_t", 32'h1000_FFFE, 0, 0, 1'b1, 1'b0);
    checks++;
    if (imem_addr_o !== 32'h0000_001C) begin
      errors++;
      $display("FAIL branch_taken: got %h expected 0000001c", imem_addr_o);
    end
    run_instr("to20b", 32'h0800_0008, 1, 0, 1'b0, 1'b1);
    run_instr("beq_nt", 32'h1000_FFFE, 0, 2, 1'b0, 1'b0);
    checks++;
    if (imem_addr_o !== 32'h0000_0024) begin
      errors++;
      $display("FAIL branch_not_taken: got %h expected 00000024", imem_addr_o);
    end
  endtask

  task automatic test_jump_priority();
    for (int r = 0; r < 4; r++) begin
      run_instr("jregion", 32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1);
      run_instr("sregion", 32'h0000_0000, 0, 0, 1'b0, 1'b0);
    end
    checks++;
    if (pc_o !== 32'h4000_0000) begin
      errors++;
      $display("FAIL jump_setup: pc=%h expected 40000000", pc_o);
    end
    run_instr("jprio", 32'h0800_0010, 0, 0, 1'b1, 1'b1);
    checks++;
    if (imem_addr_o !== 32'h4000_0040) begin
      errors++;
      $display("FAIL jump_priority: got %h expected 40000040", imem_addr_o);
    end
  endtask

  task automatic test_wrap();
    while (pc_m != 32'hFFFF_FFFC) begin
      run_instr("jwrap", 32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1);
      if (pc_m != 32'hFFFF_FFFC) run_instr("swrap", 32'h0000_0000, 0, 0, 1'b0, 1'b0);
    end
    run_instr("wrap", 32'h0000_0000, 0, 0, 1'b0, 1'b0);
    checks++;
    if (imem_addr_o !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: got %h expected 00000000", imem_addr_o);
    end
    run_instr("negbr", 32'h1000_FFFE, 0, 0, 1'b1, 1'b0);
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL branch_wrap: got %h expected fffffffc", imem_addr_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h0000_0000 || instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h valid=%0b req=%0b, expected 00000000/0/0", pc_o, instr_valid_o, imem_req_o);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (instr_o !== 32'h0000_0000 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_rvalid: instr=%h valid=%0b, expected 00000000/0", instr_o, instr_valid_o);
    end
    imem_rvalid_i = 1'b0;
    rst_ni = 1'b1;
    pc_m = 32'h0000_0000;
    @(negedge clk_i);
    run_instr("post_rst", 32'h2000_0001, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      run_instr("rand", ins, $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_state();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
